jump_operand_forward: RTL and testbench
=======================================

Name: jump_operand_forward

Overview:
- Parametrised operand-resolution unit for ID-stage control transfers (jr/jalr/branch compares); generalises single-operand jump-register forwarding.
- Resolves two source operands against N in-flight producer stages, youngest first. Detects producers whose result is not yet available, such as loads.
- Holds ID in a stall state machine until both operands resolve. Delivers registered operands one cycle after resolution.

Parameters:
- DATA_W, 32, operand/data width.
- ADDR_W, 5, register address width.
- NUM_STAGES, 3, producer stages checked; index 0 is youngest (EX), then MEM, WB.
- MAX_STALL, 8, stall cycles before timeout fallback.
- CNT_W, 16, stall performance counter width.
- Derived localparam SRC_W = clog2(NUM_STAGES+2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  ID presents a jump/branch needing operands.
- req_addr_a  in  ADDR_W  source A register.
- req_addr_b  in  ADDR_W  source B register.
- rf_data_a  in  DATA_W  register-file read of A, valid every cycle for the current address.
- rf_data_b  in  DATA_W  register-file read of B.
- stg_wr_en  in  NUM_STAGES  stage i writes a register.
- stg_addr  in  NUM_STAGES*ADDR_W  destination address; stage i at bits [i*ADDR_W +: ADDR_W].
- stg_data  in  NUM_STAGES*DATA_W  stage result, packed the same way.
- stg_rdy  in  NUM_STAGES  stage i result valid this cycle.
- flush  in  1  abort the outstanding request.
- stall  out  1  freeze PC/IF/ID.
- resp_valid  out  1  one-cycle pulse; operands valid.
- opnd_a  out  DATA_W  resolved operand A (registered).
- opnd_b  out  DATA_W  resolved operand B (registered).
- src_a  out  SRC_W  source of A: 0 = regfile, i+1 = stage i, NUM_STAGES+1 = zero register.
- src_b  out  SRC_W  source of B, same encoding.
- timeout  out  1  one-cycle pulse; resolution forced by MAX_STALL.
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Clears stall, resp_valid, timeout, opnd_a/b, src_a/b and stall_cnt, and the latched addresses. All take effect immediately, mid-stall included.
- Per-operand resolution (combinational):
  - Address 0 resolves to 0 with src=NUM_STAGES+1; stages are never consulted.
  - Otherwise select the lowest i with stg_wr_en[i]=1 and a matching address.
  - If that stage has stg_rdy[i]=1, the operand resolves to its data.
  - If that stage has stg_rdy[i]=0, the operand is blocked. Older matching stages are ignored, since their values are stale.
  - If no stage matches, the operand resolves to rf_data, src=0.
- Operand addresses: in IDLE the resolver uses req_addr_*; in STALL it uses the latched addresses.
- FSM states: IDLE, STALL.
  - IDLE, req_valid=1, both operands resolved:
    - Capture opnd/src on this edge.
    - resp_valid=1 next cycle (latency 1).
    - Remain in IDLE; stall=0.
  - IDLE, req_valid=1, either operand blocked:
    - stall=1 combinationally this cycle.
    - Latch both addresses, clear the wait counter, go to STALL.
  - STALL:
    - stall=1; resolution re-runs each cycle against current stage inputs, since bubbles advance the pipeline.
    - When both operands resolve: capture, pulse resp_valid next cycle, return to IDLE.
    - stall=0 in the resolving cycle.
  - STALL, wait counter reaches MAX_STALL-1 with an operand still blocked:
    - Blocked operands take rf_data (src=0); resolved operands keep their normal resolution.
    - Pulse timeout together with resp_valid next cycle; go to IDLE.
  - flush=1 in any state:
    - Next state IDLE, no resp_valid, stall=0 that cycle.
    - flush has priority over resolution and timeout.
- req_valid in STALL is ignored; ID is frozen and holds the same request.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- opnd/src hold their last values between responses.

Test Plan:
- ALU hazard: EX wr_en, addr=5, data=0x100, rdy=1; req_addr_a=5 -> no stall; next cycle resp_valid=1, opnd_a=0x100, src_a=1.
- Load-use: EX addr=8 rdy=0, MEM addr=8 data=0xDEAD rdy=1; req_a=8 -> stall 1 cycle. Next cycle MEM addr=8, data=0xBEEF, rdy=1 -> resp_valid, opnd_a=0xBEEF, src_a=2, stall_cnt=1.
- Zero/regfile: req_a=0 with EX addr=0 wr_en=1 data=7; req_b=3 with no match, rf_data_b=0x55 -> opnd_a=0, src_a=4, opnd_b=0x55, src_b=0.
- Timeout: EX addr=9 rdy=0 held for MAX_STALL=8 cycles, rf_data_a=0x11 -> exactly 8 stall cycles; resp_valid and timeout pulse; opnd_a=0x11.
- Flush and reset mid-stall: enter STALL, assert flush -> IDLE, no resp_valid. Re-enter STALL, drop rst_n -> stall=0, stall_cnt=0 immediately.
- Saturation: CNT_W=4, stall for 20 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/jump_operand_forward.sv
// Operand resolution for ID-stage jumps/branches: forwards both sources from
// in-flight producers (youngest first) and stalls ID until they are available.
module jump_operand_forward #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_STAGES = 3,
    parameter int MAX_STALL  = 8,
    parameter int CNT_W      = 16,
    localparam int SRC_W     = $clog2(NUM_STAGES + 2)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    input  logic [ADDR_W-1:0]              req_addr_a,
    input  logic [ADDR_W-1:0]              req_addr_b,
    input  logic [DATA_W-1:0]              rf_data_a,
    input  logic [DATA_W-1:0]              rf_data_b,
    input  logic [NUM_STAGES-1:0]          stg_wr_en,
    input  logic [NUM_STAGES*ADDR_W-1:0]   stg_addr,
    input  logic [NUM_STAGES*DATA_W-1:0]   stg_data,
    input  logic [NUM_STAGES-1:0]          stg_rdy,
    input  logic                           flush,
    output logic                           stall,
    output logic                           resp_valid,
    output logic [DATA_W-1:0]              opnd_a,
    output logic [DATA_W-1:0]              opnd_b,
    output logic [SRC_W-1:0]               src_a,
    output logic [SRC_W-1:0]               src_b,
    output logic                           timeout,
    output logic [CNT_W-1:0]               stall_cnt
);

    localparam int WAIT_W = $clog2(MAX_STALL) + 1;
    localparam int RES_W  = 1 + SRC_W + DATA_W;

    typedef enum logic {IDLE, STALL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   opnd_a_q, opnd_a_d, opnd_b_q, opnd_b_d;
    logic [SRC_W-1:0]    src_a_q, src_a_d, src_b_q, src_b_d;
    logic                resp_q, resp_d, to_q, to_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [ADDR_W-1:0]   cur_a, cur_b;
    logic                blk_a, blk_b, stall_c, capture, force_rf;
    logic [SRC_W-1:0]    rsrc_a, rsrc_b;
    logic [DATA_W-1:0]   rdat_a, rdat_b;

    // Loop runs oldest to youngest so the youngest matching stage wins; a
    // not-ready youngest match blocks even if an older stage holds the value.
    function automatic logic [RES_W-1:0] resolve(
        input logic [ADDR_W-1:0]            addr,
        input logic [DATA_W-1:0]            rf,
        input logic [NUM_STAGES-1:0]        wr,
        input logic [NUM_STAGES*ADDR_W-1:0] sa,
        input logic [NUM_STAGES*DATA_W-1:0] sd,
        input logic [NUM_STAGES-1:0]        rdy
    );
        logic              blk;
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] d;
        blk = 1'b0;
        src = '0;
        d   = rf;
        if (addr == '0) begin
            src = SRC_W'(NUM_STAGES + 1);
            d   = '0;
        end else begin
            for (int i = NUM_STAGES - 1; i >= 0; i--) begin
                if (wr[i] && sa[i*ADDR_W +: ADDR_W] == addr) begin
                    src = SRC_W'(i + 1);
                    d   = sd[i*DATA_W +: DATA_W];
                    blk = !rdy[i];
                end
            end
        end
        return {blk, src, d};
    endfunction

    always_comb begin
        cur_a = (state_q == STALL) ? addr_a_q : req_addr_a;
        cur_b = (state_q == STALL) ? addr_b_q : req_addr_b;
        {blk_a, rsrc_a, rdat_a} = resolve(cur_a, rf_data_a, stg_wr_en, stg_addr, stg_data, stg_rdy);
        {blk_b, rsrc_b, rdat_b} = resolve(cur_b, rf_data_b, stg_wr_en, stg_addr, stg_data, stg_rdy);
    end

    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        wait_d   = wait_q;
        stall_c  = 1'b0;
        capture  = 1'b0;
        force_rf = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    if (blk_a || blk_b) begin
                        stall_c  = 1'b1;
                        addr_a_d = req_addr_a;
                        addr_b_d = req_addr_b;
                        wait_d   = '0;
                        state_d  = STALL;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            STALL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (!blk_a && !blk_b) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (wait_q == WAIT_W'(MAX_STALL - 1)) begin
                    capture  = 1'b1;
                    force_rf = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall_c = 1'b1;
                    wait_d  = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only a forced resolution can capture a blocked operand; it falls back to the regfile.
    always_comb begin
        opnd_a_d = opnd_a_q;
        opnd_b_d = opnd_b_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        resp_d   = capture;
        to_d     = force_rf;
        if (capture) begin
            opnd_a_d = blk_a ? rf_data_a : rdat_a;
            src_a_d  = blk_a ? '0 : rsrc_a;
            opnd_b_d = blk_b ? rf_data_b : rdat_b;
            src_b_d  = blk_b ? '0 : rsrc_b;
        end
        cnt_d = cnt_q;
        if (stall_c && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            wait_q   <= '0;
            opnd_a_q <= '0;
            opnd_b_q <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            resp_q   <= 1'b0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            wait_q   <= wait_d;
            opnd_a_q <= opnd_a_d;
            opnd_b_q <= opnd_b_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            resp_q   <= resp_d;
            to_q     <= to_d;
            cnt_q    <= cnt_d;
        end
    end

    // Gated by reset so a request held across reset cannot keep ID frozen.
    assign stall      = stall_c & rst_n;
    assign resp_valid = resp_q;
    assign timeout    = to_q;
    assign opnd_a     = opnd_a_q;
    assign opnd_b     = opnd_b_q;
    assign src_a      = src_a_q;
    assign src_b      = src_b_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_jump_operand_forward.sv
// Bench for jump_operand_forward: vector table plus load-use, timeout,
// flush, reset and counter-saturation sequences, checked via a scoreboard.
module tb_jump_operand_forward;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 3;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_valid_s = 1'b0, flush = 1'b0;
    logic [AW-1:0] req_addr_a = '0, req_addr_b = '0;
    logic [DW-1:0] rf_data_a = '0, rf_data_b = '0;
    logic [NS-1:0] stg_wr_en = '0, stg_rdy = '0;
    logic [NS*AW-1:0] stg_addr = '0;
    logic [NS*DW-1:0] stg_data = '0;

    logic stall, resp_valid, timeout;
    logic [DW-1:0] opnd_a, opnd_b;
    logic [SW-1:0] src_a, src_b;
    logic [15:0] stall_cnt;

    logic stall_s, resp_s, to_s;
    logic [DW-1:0] oa_s, ob_s;
    logic [SW-1:0] sa_s, sb_s;
    logic [3:0] cnt_s;

    always #5 clk = ~clk;

    jump_operand_forward dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .stg_wr_en(stg_wr_en), .stg_addr(stg_addr), .stg_data(stg_data),
        .stg_rdy(stg_rdy), .flush(flush), .stall(stall),
        .resp_valid(resp_valid), .opnd_a(opnd_a), .opnd_b(opnd_b),
        .src_a(src_a), .src_b(src_b), .timeout(timeout), .stall_cnt(stall_cnt)
    );

    jump_operand_forward #(.MAX_STALL(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_s),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .stg_wr_en(stg_wr_en), .stg_addr(stg_addr), .stg_data(stg_data),
        .stg_rdy(stg_rdy), .flush(flush), .stall(stall_s),
        .resp_valid(resp_s), .opnd_a(oa_s), .opnd_b(ob_s),
        .src_a(sa_s), .src_b(sb_s), .timeout(to_s), .stall_cnt(cnt_s)
    );

    typedef struct {
        logic [DW-1:0] a, b;
        logic [SW-1:0] sa, sb;
        logic          to;
    } exp_t;

    typedef struct {
        logic [NS-1:0] wr, rdy;
        logic [AW-1:0] a0, a1, a2;
        logic [DW-1:0] d0, d1, d2;
        logic [AW-1:0] ra, rb;
        logic [DW-1:0] rfa, rfb;
        logic [DW-1:0] ea, eb;
        logic [SW-1:0] esa, esb;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[6];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_stage(input int i, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic r);
        stg_wr_en[i]         = wr;
        stg_addr[i*AW +: AW] = a;
        stg_data[i*DW +: DW] = d;
        stg_rdy[i]           = r;
    endtask

    task automatic clear_stages();
        stg_wr_en = '0;
        stg_addr  = '0;
        stg_data  = '0;
        stg_rdy   = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (timeout && !resp_valid) chk("timeout without resp", 32'(timeout), 32'(0));
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected resp_valid", 32'(resp_valid), 32'(0));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp opnd_a", opnd_a, e.a);
                    chk("resp opnd_b", opnd_b, e.b);
                    chk("resp src_a", 32'(src_a), 32'(e.sa));
                    chk("resp src_b", 32'(src_b), 32'(e.sb));
                    chk("resp timeout", 32'(timeout), 32'(e.to));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{wr:3'b001, rdy:3'b001, a0:5, a1:0, a2:0, d0:32'h100, d1:0, d2:0,
                    ra:5, rb:0, rfa:32'hAAAA, rfb:32'hBBBB, ea:32'h100, eb:0, esa:1, esb:4};
        vecs[1] = '{wr:3'b001, rdy:3'b001, a0:0, a1:0, a2:0, d0:7, d1:0, d2:0,
                    ra:0, rb:3, rfa:32'hAAAA, rfb:32'h55, ea:0, eb:32'h55, esa:4, esb:0};
        vecs[2] = '{wr:3'b011, rdy:3'b011, a0:6, a1:6, a2:0, d0:32'hA, d1:32'hB, d2:0,
                    ra:6, rb:6, rfa:32'hAAAA, rfb:32'hBBBB, ea:32'hA, eb:32'hA, esa:1, esb:1};
        vecs[3] = '{wr:3'b100, rdy:3'b111, a0:7, a1:0, a2:7, d0:32'h999, d1:0, d2:32'h77,
                    ra:7, rb:2, rfa:32'hAAAA, rfb:32'h22, ea:32'h77, eb:32'h22, esa:3, esb:0};
        vecs[4] = '{wr:3'b011, rdy:3'b011, a0:1, a1:2, a2:0, d0:32'h111, d1:32'h222, d2:0,
                    ra:2, rb:1, rfa:32'hAAAA, rfb:32'hBBBB, ea:32'h222, eb:32'h111, esa:2, esb:1};
        vecs[5] = '{wr:3'b011, rdy:3'b001, a0:4, a1:4, a2:0, d0:32'h44, d1:32'h4444, d2:0,
                    ra:4, rb:31, rfa:32'hAAAA, rfb:32'h3131, ea:32'h44, eb:32'h3131, esa:1, esb:0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", 32'(stall), 0);
        chk("reset resp_valid", 32'(resp_valid), 0);
        chk("reset timeout", 32'(timeout), 0);
        chk("reset opnd_a", opnd_a, 0);
        chk("reset src_a", 32'(src_a), 0);
        chk("reset stall_cnt", 32'(stall_cnt), 0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            clear_stages();
            set_stage(0, vecs[k].wr[0], vecs[k].a0, vecs[k].d0, vecs[k].rdy[0]);
            set_stage(1, vecs[k].wr[1], vecs[k].a1, vecs[k].d1, vecs[k].rdy[1]);
            set_stage(2, vecs[k].wr[2], vecs[k].a2, vecs[k].d2, vecs[k].rdy[2]);
            req_addr_a = vecs[k].ra; req_addr_b = vecs[k].rb;
            rf_data_a  = vecs[k].rfa; rf_data_b = vecs[k].rfb;
            req_valid  = 1'b1;
            #1 chk($sformatf("vec%0d stall", k), 32'(stall), 0);
            sbq.push_back('{a:vecs[k].ea, b:vecs[k].eb, sa:vecs[k].esa, sb:vecs[k].esb, to:1'b0});
            @(posedge clk); #1;
            req_valid = 1'b0;
            clear_stages();
        end

        // load-use: EX load not ready, then MEM delivers
        @(posedge clk); #1;
        set_stage(0, 1, 8, 32'h0, 0);
        set_stage(1, 1, 8, 32'hDEAD, 1);
        req_addr_a = 8; req_addr_b = 0; req_valid = 1'b1;
        #1 chk("loaduse stall0", 32'(stall), 1);
        sbq.push_back('{a:32'hBEEF, b:0, sa:2, sb:4, to:1'b0});
        @(posedge clk); #1;
        clear_stages();
        set_stage(1, 1, 8, 32'hBEEF, 1);
        #1 chk("loaduse stall1", 32'(stall), 0);
        @(posedge clk); #1;
        req_valid = 1'b0; clear_stages();
        chk("loaduse stall_cnt", 32'(stall_cnt), 1);

        // timeout: EX never ready
        @(posedge clk); #1;
        set_stage(0, 1, 9, 32'h999, 0);
        rf_data_a = 32'h11; req_addr_a = 9; req_addr_b = 0; req_valid = 1'b1;
        sbq.push_back('{a:32'h11, b:0, sa:0, sb:4, to:1'b1});
        n = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (stall) n++;
            else break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; clear_stages();
        chk("timeout stall cycles", 32'(n), 8);
        chk("timeout stall_cnt", 32'(stall_cnt), 9);

        // flush mid-stall: no response, operands hold
        @(posedge clk); #1;
        set_stage(0, 1, 10, 0, 0);
        req_addr_a = 10; req_addr_b = 0; req_valid = 1'b1;
        #1 chk("flush stall0", 32'(stall), 1);
        @(posedge clk); #1;
        flush = 1'b1;
        #1 chk("flush stall", 32'(stall), 0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0; clear_stages();
        repeat (3) @(posedge clk);
        #1;
        chk("flush hold opnd_a", opnd_a, 32'h11);
        chk("flush hold src_a", 32'(src_a), 0);
        chk("flush stall_cnt", 32'(stall_cnt), 10);

        // reset mid-stall
        @(posedge clk); #1;
        set_stage(0, 1, 10, 0, 0);
        req_addr_a = 10; req_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst pre stall", 32'(stall), 1);
        rst_n = 1'b0;
        #1;
        chk("rst stall", 32'(stall), 0);
        chk("rst stall_cnt", 32'(stall_cnt), 0);
        chk("rst resp_valid", 32'(resp_valid), 0);
        req_valid = 1'b0; clear_stages();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // saturation on the 4-bit counter instance
        @(posedge clk); #1;
        set_stage(0, 1, 12, 0, 0);
        req_addr_a = 12; req_valid_s = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("sat mid cnt", 32'(cnt_s), 10);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_valid_s = 1'b0; clear_stages();
        chk("sat stall_cnt", 32'(cnt_s), 15);

        repeat (3) @(posedge clk);
        #1 chk("scoreboard drained", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
